signed_bcd_display: RTL and testbench

Sequential signed binary-to-decimal display driver for the DE1-SoC seven-segment bank. It accepts a signed two's-complement value of parametrised width and converts it to decimal with a multi-cycle shift-and-add-3 (double-dabble) engine. It drives a sign digit plus `NumDigits` magnitude digits. It is the multi-digit, arbitrary-width successor of the combinational 4-bit signed decoder, and sits between datapath results (ALU, counters) and the HEX outputs of FPGA top-levels.

---
 rtl/DisplayPkg.sv | 35 +++
 rtl/seven_seg_digit.sv | 17 +
 rtl/signed_bcd_display.sv | 154 +++++++++++++++
 tb/tb_signed_bcd_display.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/DisplayPkg.sv
// rtl/DisplayPkg.sv - shared segment encodings, FSM states and BCD sizing helper
// Contents: tSegment, SegDigit[0:9], SegBlank, SegMinus, tState, BcdDigitsFor()
package DisplayPkg;

    typedef logic [6:0] tSegment;

    // Active-low gfedcba patterns
    localparam tSegment SegBlank = 7'h7F;
    localparam tSegment SegMinus = 7'h3F;
    localparam tSegment SegDigit [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } tState;

    // Decimal digits needed for 2^(width-1), the largest magnitude of a
    // width-bit two's-complement value (width <= 64).
    function automatic int BcdDigitsFor(input int width);
        longint unsigned v;
        int              d;
        v = 64'd1 << (width - 1);
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_digit.sv
// rtl/seven_seg_digit.sv - combinational BCD to active-low seven-segment decoder
// Ports: bcd (4-bit code in), seg (active-low gfedcba out; blank for 10-15)
module seven_seg_digit
    import DisplayPkg::*;
(
    input  logic [3:0] bcd,
    output tSegment    seg
);

    always_comb begin
        seg = SegBlank;
        if (bcd <= 4'd9) begin
            seg = SegDigit[bcd];
        end
    end

endmodule

// File: rtl/signed_bcd_display.sv
// rtl/signed_bcd_display.sv - sequential signed binary to seven-segment decimal display driver
// Ports: Clock, nReset (async active-low), Start/Value (request + signed operand),
//        Busy, Done (one-cycle pulse), Overflow, Segments (sign digit on top, units at [6:0]).
// Build option: SIGNED_BCD_DISPLAY_BLANK_EN enables leading-zero suppression.
module signed_bcd_display
    import DisplayPkg::*;
#(
    parameter int DataWidth = 8,
    parameter int NumDigits = 3
) (
    input  logic                         Clock,
    input  logic                         nReset,
    input  logic                         Start,
    input  logic [DataWidth-1:0]         Value,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Overflow,
    output logic [(NumDigits+1)*7-1:0]   Segments
);

    localparam int BcdDigits = BcdDigitsFor(DataWidth);
    // Wide enough to address every displayed digit and every converted digit
    localparam int ExtDigits = (NumDigits > BcdDigits) ? NumDigits : BcdDigits;
    localparam int CntWidth  = $clog2(DataWidth + 1);

    tState                        state;
    tState                        state_next;
    logic [DataWidth-1:0]         mag;
    logic [BcdDigits*4-1:0]       bcd;
    logic [BcdDigits*4-1:0]       bcd_adj;
    logic [ExtDigits*4-1:0]       bcd_ext;
    logic [CntWidth-1:0]          count;
    logic                         negative;
    tSegment                      digit_seg [NumDigits];
    logic [(NumDigits+1)*7-1:0]   seg_next;
    logic                         ovf_next;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            StIdle:   if (Start) state_next = StShift;
            StShift:  if (count == CntWidth'(1)) state_next = StUpdate;
            StUpdate: state_next = StIdle;
            default:  state_next = StIdle;
        endcase
    end

    assign Busy = (state != StIdle);

    // Add-3 correction applied to every digit before each shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BcdDigits; i++) begin
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3)
                                                        : bcd[i*4 +: 4];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mag      <= '0;
            bcd      <= '0;
            count    <= '0;
            negative <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (Start) begin
                        negative <= Value[DataWidth-1];
                        // Unsigned DataWidth bits hold 2^(DataWidth-1) exactly
                        mag      <= Value[DataWidth-1] ? (-Value) : Value;
                        bcd      <= '0;
                        count    <= CntWidth'(DataWidth);
                    end
                end
                StShift: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    count      <= count - CntWidth'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bcd_ext = '0;
        bcd_ext[BcdDigits*4-1:0] = bcd;
    end

    for (genvar g = 0; g < NumDigits; g++) begin : g_digit
        seven_seg_digit u_digit (
            .bcd (bcd_ext[g*4 +: 4]),
            .seg (digit_seg[g])
        );
    end

    always_comb begin
        ovf_next = 1'b0;
        for (int i = NumDigits; i < ExtDigits; i++) begin
            if (bcd_ext[i*4 +: 4] != 4'd0) ovf_next = 1'b1;
        end
    end

    always_comb begin
`ifdef SIGNED_BCD_DISPLAY_BLANK_EN
        logic leading;
        leading  = 1'b1;
`endif
        seg_next = '1;
        // Scan from the most significant digit down so blanking stops at the
        // first nonzero digit; the units digit always shows.
        for (int i = NumDigits - 1; i >= 0; i--) begin
`ifdef SIGNED_BCD_DISPLAY_BLANK_EN
            if (leading && (i != 0) && (bcd_ext[i*4 +: 4] == 4'd0)) begin
                seg_next[i*7 +: 7] = SegBlank;
            end else begin
                leading            = 1'b0;
                seg_next[i*7 +: 7] = digit_seg[i];
            end
`else
            seg_next[i*7 +: 7] = digit_seg[i];
`endif
        end
        seg_next[NumDigits*7 +: 7] = negative ? SegMinus : SegBlank;
        if (ovf_next) begin
            seg_next = {(NumDigits+1){SegMinus}};
        end
    end

    // Outputs only change on the UPDATE edge so the display never shows
    // intermediate shift results.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Segments <= '1;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= (state == StUpdate);
            if (state == StUpdate) begin
                Segments <= seg_next;
                Overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_signed_bcd_display.sv
// tb/tb_signed_bcd_display.sv - directed self-checking bench for signed_bcd_display
module tb_signed_bcd_display;

`ifdef SIGNED_BCD_DISPLAY_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] SM = 7'h3F;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  Value = 8'd0;
    logic        Busy, Done, Overflow;
    logic [27:0] Segments;
    logic        Busy2, Done2, Overflow2;
    logic [20:0] Segments2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    signed_bcd_display u_dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Start    (Start),
        .Value    (Value),
        .Busy     (Busy),
        .Done     (Done),
        .Overflow (Overflow),
        .Segments (Segments)
    );

    signed_bcd_display #(.DataWidth(8), .NumDigits(2)) u_dut2 (
        .Clock    (Clock),
        .nReset   (nReset),
        .Start    (Start),
        .Value    (Value),
        .Busy     (Busy2),
        .Done     (Done2),
        .Overflow (Overflow2),
        .Segments (Segments2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic start_now(input logic [7:0] v, output logic busy_seen);
        Value = v;
        Start = 1'b1;
        @(posedge Clock); #1;
        busy_seen = Busy;
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic conv_case(input string tag, input logic [7:0] v,
                             input logic [27:0] e1, input logic o1,
                             input logic [20:0] e2, input logic o2);
        int   lat;
        logic bs;
        @(negedge Clock);
        start_now(v, bs);
        wait_done(lat);
        check({tag, " busy"}, 32'(bs), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " seg"}, 32'(Segments), 32'(e1));
        check({tag, " ovf"}, 32'(Overflow), 32'(o1));
        check({tag, " seg2"}, 32'(Segments2), 32'(e2));
        check({tag, " ovf2"}, 32'(Overflow2), 32'(o2));
        check({tag, " done2"}, 32'(Done2), 32'd1);
    endtask

    initial begin
        int   lat;
        logic bs;
        int   done_seen;

        repeat (3) @(posedge Clock);
        #1;
        check("rst seg", 32'(Segments), 32'h0FFFFFFF);
        check("rst seg2", 32'(Segments2), 32'h001FFFFF);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst ovf", 32'(Overflow), 32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        conv_case("p123", 8'd123, {SB, 7'h79, 7'h24, 7'h30}, 1'b0, {SM, SM, SM}, 1'b1);
        // Done pulse width and hold of the result afterwards
        @(posedge Clock); #1;
        check("done width", 32'(Done), 32'd0);
        check("busy idle", 32'(Busy), 32'd0);
        check("seg hold", 32'(Segments), 32'({SB, 7'h79, 7'h24, 7'h30}));

        conv_case("n128", 8'h80, {SM, 7'h79, 7'h24, 7'h00}, 1'b0, {SM, SM, SM}, 1'b1);
        conv_case("p100", 8'd100, {SB, 7'h79, 7'h40, 7'h40}, 1'b0, {SM, SM, SM}, 1'b1);
        conv_case("p99", 8'd99, {SB, LZ, 7'h10, 7'h10}, 1'b0, {SB, 7'h10, 7'h10}, 1'b0);
        conv_case("n99", 8'h9D, {SM, LZ, 7'h10, 7'h10}, 1'b0, {SM, 7'h10, 7'h10}, 1'b0);
        conv_case("p5", 8'd5, {SB, LZ, LZ, 7'h12}, 1'b0, {SB, LZ, 7'h12}, 1'b0);
        conv_case("n7", 8'hF9, {SM, LZ, LZ, 7'h78}, 1'b0, {SM, LZ, 7'h78}, 1'b0);
        conv_case("zero", 8'd0, {SB, LZ, LZ, 7'h40}, 1'b0, {SB, LZ, 7'h40}, 1'b0);

        // Start while busy is ignored; Value changes after capture
        @(negedge Clock);
        start_now(8'd3, bs);
        repeat (3) begin @(posedge Clock); #1; end
        Start = 1'b1;
        Value = 8'hCE;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(lat);
        check("ign latency", 32'(lat), 32'd5);
        check("ign seg", 32'(Segments), 32'({SB, LZ, LZ, 7'h30}));

        // Start in the Done cycle is accepted
        start_now(8'd42, bs);
        check("b2b busy", 32'(bs), 32'd1);
        check("b2b hold", 32'(Segments), 32'({SB, LZ, LZ, 7'h30}));
        wait_done(lat);
        check("b2b latency", 32'(lat), 32'd9);
        check("b2b seg", 32'(Segments), 32'({SB, LZ, 7'h19, 7'h24}));
        check("b2b seg2", 32'(Segments2), 32'({SB, 7'h19, 7'h24}));

        // Reset mid-conversion aborts without a Done
        @(negedge Clock);
        start_now(8'd77, bs);
        repeat (3) begin @(posedge Clock); #1; end
        nReset = 1'b0;
        #1;
        check("abort seg", 32'(Segments), 32'h0FFFFFFF);
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort ovf", 32'(Overflow2), 32'd0);
        @(negedge Clock);
        nReset = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(posedge Clock); #1;
            if (Done || Done2 || Busy) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);

        conv_case("post", 8'd42, {SB, LZ, 7'h19, 7'h24}, 1'b0, {SB, 7'h19, 7'h24}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
